// File: rtl/ball_motion_if.sv
// ---------------------------------------------------------------------------
// ball_motion_if
// Velocity/direction load port of the ball kinematics engine. The cue-shot
// logic or the ball-pair collision block is the master; ball_motion is the
// slave. A load transfers when hit_valid && hit_ready.
//
//   hit_valid   master -> slave  load request
//   hit_ready   slave  -> master load accepted this cycle
//   hit_vx/vy   master -> slave  signed 5-bit speed (magnitude is taken)
//   hit_dx/dy   master -> slave  signed 2-bit direction (bit1 set = -1)
// ---------------------------------------------------------------------------
interface ball_motion_if;
    logic              hit_valid;
    logic              hit_ready;
    logic signed [4:0] hit_vx;
    logic signed [4:0] hit_vy;
    logic signed [1:0] hit_dx;
    logic signed [1:0] hit_dy;

    modport master (
        output hit_valid,
        output hit_vx,
        output hit_vy,
        output hit_dx,
        output hit_dy,
        input  hit_ready
    );

    modport slave (
        input  hit_valid,
        input  hit_vx,
        input  hit_vy,
        input  hit_dx,
        input  hit_dy,
        output hit_ready
    );
endinterface

// File: rtl/ball_motion.sv
// ---------------------------------------------------------------------------
// ball_motion
// Kinematics engine for one billiard ball. Holds the ball centre, the speed
// magnitudes and the direction signs. Once per frame (frame_tick) it spends
// one STEP cycle integrating position, reflecting off the cushions and
// applying friction. New velocity/direction arrive over the hit port.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   frame_tick  one-cycle pulse per video frame
//   hit         load port (slave side of ball_motion_if)
//   x, y        ball centre, unsigned pixels
//   vx, vy      speed magnitudes, 0..15
//   dx, dy      direction, +1 (2'b01) or -1 (2'b11)
//   moving      high while either speed is nonzero
//   wall_hit    one-cycle pulse on a cushion reflection
// ---------------------------------------------------------------------------
module ball_motion #(
    parameter int BALL_R          = 12,
    parameter int X_MIN           = 20,
    parameter int X_MAX           = 620,
    parameter int Y_MIN           = 20,
    parameter int Y_MAX           = 460,
    parameter int X_INIT          = 320,
    parameter int Y_INIT          = 240,
    parameter int FRICTION_PERIOD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    ball_motion_if.slave      hit,
    output logic [9:0]        x,
    output logic [9:0]        y,
    output logic signed [4:0] vx,
    output logic signed [4:0] vy,
    output logic signed [1:0] dx,
    output logic signed [1:0] dy,
    output logic              moving,
    output logic              wall_hit
);

    // FSM encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MOVE = 2'd1;
    localparam logic [1:0] STEP = 2'd2;

    localparam logic [1:0] DIR_POS = 2'b01;
    localparam logic [1:0] DIR_NEG = 2'b11;

    // Friction counter sized for FRICTION_PERIOD values 0..FRICTION_PERIOD-1
    localparam int             FC_W    = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRICTION_PERIOD - 1);

    // Cushion geometry in the 12-bit signed integration domain
    localparam logic signed [11:0] R12   = 12'(BALL_R);
    localparam logic signed [11:0] X_LO  = 12'(X_MIN);
    localparam logic signed [11:0] X_HI  = 12'(X_MAX);
    localparam logic signed [11:0] Y_LO  = 12'(Y_MIN);
    localparam logic signed [11:0] Y_HI  = 12'(Y_MAX);

    // Centre position when parked against each cushion
    localparam logic [9:0] X_PARK_LO = 10'(X_MIN + BALL_R);
    localparam logic [9:0] X_PARK_HI = 10'(X_MAX - BALL_R);
    localparam logic [9:0] Y_PARK_LO = 10'(Y_MIN + BALL_R);
    localparam logic [9:0] Y_PARK_HI = 10'(Y_MAX - BALL_R);

    typedef struct packed {
        logic [9:0] pos;
        logic [1:0] dir;
        logic       hit;
    } axis_t;

    // Magnitude of a signed 5-bit speed; -16 has no positive twin and saturates to 15.
    function automatic logic [4:0] abs_sat(input logic [4:0] v);
        logic [4:0] r;
        if (v == 5'b10000) begin
            r = 5'd15;
        end else if (v[4]) begin
            r = ~v + 5'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Direction load: any value with bit1 set means -1, everything else +1.
    function automatic logic [1:0] dir_load(input logic [1:0] d);
        logic [1:0] r;
        if (d[1]) begin
            r = DIR_NEG;
        end else begin
            r = DIR_POS;
        end
        return r;
    endfunction

    // One unit of friction; a stopped axis stays stopped.
    function automatic logic [4:0] speed_dec(input logic [4:0] s);
        logic [4:0] r;
        if (s != 5'd0) begin
            r = s - 5'd1;
        end else begin
            r = s;
        end
        return r;
    endfunction

    // One axis of integration with cushion reflection. The move is done in
    // 12-bit signed so that a step past the left/top cushion goes negative
    // instead of wrapping.
    function automatic axis_t axis_step(
        input logic [9:0]        pos,
        input logic [4:0]        spd,
        input logic [1:0]        dir,
        input logic signed [11:0] lo,
        input logic signed [11:0] hi,
        input logic [9:0]        park_lo,
        input logic [9:0]        park_hi
    );
        logic signed [11:0] base;
        logic signed [11:0] delta;
        logic signed [11:0] n;
        axis_t              r;
        base  = signed'({2'b00, pos});
        delta = signed'({7'b0000000, spd});
        if (dir[1]) begin
            n = base - delta;
        end else begin
            n = base + delta;
        end
        if ((n - R12) < lo) begin
            r.pos = park_lo;
            r.dir = DIR_POS;
            r.hit = 1'b1;
        end else if ((n + R12) > hi) begin
            r.pos = park_hi;
            r.dir = DIR_NEG;
            r.hit = 1'b1;
        end else begin
            r.pos = n[9:0];
            r.dir = dir;
            r.hit = 1'b0;
        end
        return r;
    endfunction

    logic [1:0]        state_r,    state_s;
    logic [9:0]        x_r,        x_s;
    logic [9:0]        y_r,        y_s;
    logic signed [4:0] vx_r,       vx_s;
    logic signed [4:0] vy_r,       vy_s;
    logic signed [1:0] dx_r,       dx_s;
    logic signed [1:0] dy_r,       dy_s;
    logic              moving_r,   moving_s;
    logic              wall_hit_r, wall_hit_s;
    logic              pending_r,  pending_s;
    logic [FC_W-1:0]   fric_cnt_r, fric_cnt_s;

    logic              hit_ready_s;
    logic              xfer_s;
    axis_t             ax_s;
    axis_t             ay_s;

    // Loads are refused only while the integration cycle is in flight.
    assign hit_ready_s   = (state_r != STEP);
    assign hit.hit_ready = hit_ready_s;
    assign xfer_s        = hit.hit_valid && hit_ready_s;

    // Integration always uses last cycle's registered position/speed/direction.
    assign ax_s = axis_step(x_r, vx_r, dx_r, X_LO, X_HI, X_PARK_LO, X_PARK_HI);
    assign ay_s = axis_step(y_r, vy_r, dy_r, Y_LO, Y_HI, Y_PARK_LO, Y_PARK_HI);

    // Next-state logic: loads, tick scheduling, integration and friction.
    always_comb begin
        state_s    = state_r;
        x_s        = x_r;
        y_s        = y_r;
        vx_s       = vx_r;
        vy_s       = vy_r;
        dx_s       = dx_r;
        dy_s       = dy_r;
        wall_hit_s = 1'b0;
        pending_s  = pending_r;
        fric_cnt_s = fric_cnt_r;

        case (state_r)
            IDLE, MOVE: begin
                if (xfer_s) begin
                    // A load wins over a coincident tick; the tick is kept
                    // so the new velocity is integrated right away.
                    vx_s       = abs_sat(hit.hit_vx);
                    vy_s       = abs_sat(hit.hit_vy);
                    dx_s       = dir_load(hit.hit_dx);
                    dy_s       = dir_load(hit.hit_dy);
                    fric_cnt_s = '0;
                    pending_s  = pending_r | frame_tick;
                    if ((vx_s | vy_s) != 5'sd0) begin
                        state_s = MOVE;
                    end else begin
                        state_s = IDLE;
                    end
                end else if ((state_r == MOVE) && (frame_tick || pending_r)) begin
                    state_s   = STEP;
                    pending_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            STEP: begin
                x_s        = ax_s.pos;
                dx_s       = ax_s.dir;
                y_s        = ay_s.pos;
                dy_s       = ay_s.dir;
                wall_hit_s = ax_s.hit | ay_s.hit;
                // Friction decides on the pre-decrement speeds.
                if (fric_cnt_r == FC_LAST) begin
                    fric_cnt_s = '0;
                    vx_s       = speed_dec(vx_r);
                    vy_s       = speed_dec(vy_r);
                end else begin
                    fric_cnt_s = fric_cnt_r + FC_W'(1);
                end
                pending_s = pending_r | frame_tick;
                if ((vx_s | vy_s) == 5'sd0) begin
                    state_s = IDLE;
                end else begin
                    state_s = MOVE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        moving_s = ((vx_s | vy_s) != 5'sd0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            x_r        <= 10'(X_INIT);
            y_r        <= 10'(Y_INIT);
            vx_r       <= 5'sd0;
            vy_r       <= 5'sd0;
            dx_r       <= DIR_POS;
            dy_r       <= DIR_POS;
            moving_r   <= 1'b0;
            wall_hit_r <= 1'b0;
            pending_r  <= 1'b0;
            fric_cnt_r <= '0;
        end else begin
            state_r    <= state_s;
            x_r        <= x_s;
            y_r        <= y_s;
            vx_r       <= vx_s;
            vy_r       <= vy_s;
            dx_r       <= dx_s;
            dy_r       <= dy_s;
            moving_r   <= moving_s;
            wall_hit_r <= wall_hit_s;
            pending_r  <= pending_s;
            fric_cnt_r <= fric_cnt_s;
        end
    end

    assign x        = x_r;
    assign y        = y_r;
    assign vx       = vx_r;
    assign vy       = vy_r;
    assign dx       = dx_r;
    assign dy       = dy_r;
    assign moving   = moving_r;
    assign wall_hit = wall_hit_r;

endmodule
